seq_divider: RTL and testbench

//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU ops; the subtract-based counterpart of the datapath adder.

---
 rtl/div_pkg.sv | 28 ++
 rtl/ripple_borrow_sub.sv | 37 +++
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: RV32M op encodings, FSM states, default width.
package div_pkg;

  localparam int DIV_N = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ripple_borrow_sub.sv
// Ripple subtractor A-B built from full-adder cells (inverted B, carry-in 1).
// borrow_o is high when B > A, i.e. the inverse of the final carry.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module ripple_borrow_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);
  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (~b_i[i]),
      .cin_i (carry[i]),
      .sum_o (diff_o[i]),
      .cout_o(carry[i+1])
    );
  end

  assign borrow_o = ~carry[W];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional SEQ_DIV_ZERO_BYPASS_EN: a zero divisor skips the RUN phase (2-cycle latency).
module seq_divider
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         div_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [N-1:0]     result_q, result_d;
  div_op_e          op_q, op_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic             dsr_zero_q, dsr_zero_d, div_zero_q, div_zero_d;

  // Operand magnitudes; |MIN| = 2^(N-1) still fits as an unsigned N-bit value.
  logic         in_signed, a_neg, b_neg, b_zero;
  logic [N-1:0] a_mag, b_mag;

  assign in_signed = op_is_signed(div_op_e'(op));
  assign a_neg     = in_signed & dividend[N-1];
  assign b_neg     = in_signed & divisor[N-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign b_zero    = (divisor == '0);

  logic [N:0] shifted, trial;
  logic       borrow, trial_msb_unused;

  assign shifted = {rem_q, quo_q[N-1]};

  ripple_borrow_sub #(.W(N + 1)) u_sub (
    .a_i     (shifted),
    .b_i     ({1'b0, dsr_q}),
    .diff_o  (trial),
    .borrow_o(borrow)
  );

  // A non-borrowing trial is always below the divisor, so its top bit is zero.
  assign trial_msb_unused = trial[N];

  logic q_neg, r_neg;

  assign q_neg = (op_q == DIV_OP_DIV) & (sign_a_q ^ sign_b_q) & ~dsr_zero_q;
  assign r_neg = (op_q == DIV_OP_REM) & sign_a_q;

  // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dsr_zero_d = dsr_zero_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = div_op_e'(op);
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          dsr_d      = b_mag;
          dsr_zero_d = b_zero;
          rem_d      = '0;
          quo_d      = a_mag;
          cnt_d      = '0;
          state_d    = RUN;
`ifdef SEQ_DIV_ZERO_BYPASS_EN
          // Preload what N iterations against a zero divisor would leave behind.
          if (b_zero) begin
            rem_d   = a_mag;
            quo_d   = '1;
            state_d = FIX;
          end
`endif
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        rem_d = borrow ? shifted[N-1:0] : trial[N-1:0];
        quo_d = {quo_q[N-2:0], ~borrow};
        if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
      end

      FIX: begin
        if (op_is_rem(op_q)) result_d = r_neg ? -rem_q : rem_q;
        else                 result_d = q_neg ? -quo_q : quo_q;
        div_zero_d = dsr_zero_q;
        state_d    = DONE;
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      op_q       <= DIV_OP_DIV;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dsr_zero_q <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dsr_zero_q <= dsr_zero_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV32M corner cases plus randomized ops
// against an arithmetic reference model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int N = 32;
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend, divisor;
  logic         busy, done, div_zero;
  logic [N-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] r;
    case (o)
      DIV_OP_DIV:  r = (b == '0) ? '1 : (a == MIN && b == '1) ? MIN
                       : N'($signed(a) / $signed(b));
      DIV_OP_DIVU: r = (b == '0) ? '1 : a / b;
      DIV_OP_REM:  r = (b == '0) ? a : (a == MIN && b == '1) ? '0
                       : N'($signed(a) % $signed(b));
      default:     r = (b == '0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [N-1:0] b);
`ifdef SEQ_DIV_ZERO_BYPASS_EN
    return (b == '0) ? 2 : N + 2;
`else
    return N + 2;
`endif
  endfunction

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return MIN;
      2:       return '1;
      3:       return N'($urandom_range(1, 15));
      default: return N'($urandom);
    endcase
  endfunction

  // Launch one op, optionally re-pulse start with junk operands at poke_cycle, then check it.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int poke_cycle);
    int           cycles = 0;
    logic         busy_dropped = 1'b0;
    logic [N-1:0] exp_r;
    exp_r = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = 1'b0;
      if (cycles == poke_cycle) begin
        start = 1'b1; op = 2'($urandom); dividend = N'($urandom); divisor = N'($urandom);
      end
      if (!busy) busy_dropped = 1'b1;
    end while (!done && cycles < 4 * N);
    start = 1'b0;
    check("latency", N'(cycles), N'(exp_latency(b)));
    check("result", result, exp_r);
    check("div_zero", N'(div_zero), N'(b == '0));
    check("busy_held", N'(busy_dropped), '0);
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", N'(done), '0);
    check("busy_idle", N'(busy), '0);
    check("result_held", result, exp_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done_seen;
    rst_n = 1'b0; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    #12;
    check("rst_busy", N'(busy), '0);
    check("rst_done", N'(done), '0);
    check("rst_result", result, '0);
    check("rst_div_zero", N'(div_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(DIV_OP_DIVU, 100, 7, 0);
    run_op(DIV_OP_REMU, 100, 7, 0);
    run_op(DIV_OP_DIV, -100, 7, 0);
    run_op(DIV_OP_REM, -100, 7, 0);
    run_op(DIV_OP_REM, 100, -7, 0);
    run_op(DIV_OP_DIV, MIN, '1, 0);
    run_op(DIV_OP_REM, MIN, '1, 0);
    run_op(DIV_OP_DIV, 5, 0, 0);
    run_op(DIV_OP_REM, -5, 0, 0);
    run_op(DIV_OP_DIVU, 12345, 0, 0);
    run_op(DIV_OP_REMU, 12345, 0, 0);
    run_op(DIV_OP_DIVU, 100, 7, 10);
    run_op(DIV_OP_DIV, 77, -3, 0);

    // Reset in the middle of an op: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1; op = DIV_OP_DIVU; dividend = 32'h7FFF_1234; divisor = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", N'(busy), '0);
    check("midrst_done", N'(done), '0);
    check("midrst_result", result, '0);
    check("midrst_div_zero", N'(div_zero), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < N + 8; c++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("midrst_no_done", N'(done_seen), '0);
    run_op(DIV_OP_DIVU, 9, 3, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), rand_operand(), rand_operand(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
